ram_sp_ctrl: RTL and testbench
==============================

// Module: ram_sp_ctrl
// PURPOSE
//  Initiator-side controller for the single-port RAM: synchronous write, asynchronous read,
//  bidirectional data bus, cs/we/oe controls.
//  - Accepts host read/write requests on a valid/ready handshake.
//  - Drives the RAM address, data and control pins, manages bus direction, and returns
//    read data with a one-cycle response pulse.
//  - Sits between a host engine and the RAM instance; both are on the same clk.
// PARAMETERS
//  DATA_WIDTH  8  width of req_wdata, rsp_rdata and mem_data
//  ADDR_WIDTH  8  width of req_addr and mem_address
//  READ_WAIT   1  extra cycles cs/oe are held before read data is sampled (0..15)
//  TURNAROUND  1  idle cycles after a read before the bus may be driven again (0..15)
// PORTS
//  clk          in     1           clock; every register is on posedge clk
//  rst_n        in     1           asynchronous, active-low reset
//  req_valid    in     1           host request valid
//  req_ready    out    1           controller can accept a request (high exactly in IDLE)
//  req_we       in     1           1 = write, 0 = read
//  req_addr     in     ADDR_WIDTH  request address
//  req_wdata    in     DATA_WIDTH  write data
//  rsp_valid    out    1           one-cycle pulse: rsp_rdata holds new read data
//  rsp_rdata    out    DATA_WIDTH  read data; holds until the next read completes
//  mem_address  out    ADDR_WIDTH  RAM address
//  mem_data     inout  DATA_WIDTH  RAM data bus
//  mem_cs       out    1           RAM chip select
//  mem_we       out    1           RAM write enable
//  mem_oe       out    1           RAM output enable
// BEHAVIOUR
//  Outputs and reset
//  - All outputs come from registers, except req_ready (decoded from state) and the
//    mem_data tri-state.
//  - While rst_n=0, immediately and without waiting for clk: state=IDLE;
//    mem_cs=mem_we=mem_oe=0; mem_address=0; rsp_valid=0; rsp_rdata=0; drive_en=0,
//    so mem_data is all z.
//  - mem_data = drive_en ? wdata_q : {DATA_WIDTH{1'bz}}.
//  Accept
//  - A request is taken at a posedge where req_valid && req_ready. Call that edge N.
//  - Address and write data are captured at edge N.
//  - req_ready is low from edge N until the FSM returns to IDLE.
//  FSM: IDLE -> WR or RD; WR -> IDLE; RD -> TA (or IDLE if TURNAROUND=0); TA -> IDLE
//  - WR (exactly 1 cycle, N..N+1)
//    - mem_cs=1, mem_we=1, mem_oe=0, drive_en=1.
//    - The RAM captures the data at edge N+1.
//    - At edge N+1 all controls return to 0 and state=IDLE. Throughput is 1 write per 2 cycles.
//    - A write produces no rsp_valid.
//  - RD (READ_WAIT+1 cycles)
//    - mem_cs=1, mem_we=0, mem_oe=1, drive_en=0.
//    - A 4-bit wait counter is loaded at edge N.
//    - At edge N+1+READ_WAIT: rsp_rdata<=mem_data, rsp_valid<=1 for exactly one cycle,
//      and controls drop to 0.
//  - TA (TURNAROUND cycles): all controls 0, bus released, req_ready=0; wait counter reused.
//  Contention rules
//  - drive_en and mem_oe are never 1 in the same cycle.
//  - drive_en never rises in the cycle after mem_oe falls unless TURNAROUND=0.
//  Other rules
//  - mem_address holds its last value in IDLE and TA; it changes only at an accept edge.
//  - Addresses pass through unmodified. Hosts sequencing through 2**ADDR_WIDTH-1 wrap to 0
//    on their side; the controller adds no arithmetic.
//  - req_valid with req_ready=0 is ignored. The host holds the request stable until accepted.
//  Reset mid-operation
//  - Reset during WR before edge N+1 drops mem_cs at once, so the RAM performs no write.
//  - Reset during RD or TA: no rsp_valid; rsp_rdata=0.
//  - After rst_n rises, the first posedge may accept a request.
// TESTING (bench instantiates ram_sp_ctrl + the RAM model, DATA_WIDTH=ADDR_WIDTH=8)
//  1. Reset: hold rst_n=0 for 3 cycles with req_valid=1.
//     -> cs/we/oe=0, mem_data=8'hzz, no mem activity.
//     -> req_ready=1 on the first cycle after release.
//  2. Write 8'hA5 @8'h10, then read @8'h10, READ_WAIT=1, TURNAROUND=1.
//     -> rsp_valid exactly 2 edges after the read accept, rsp_rdata=8'hA5.
//     -> req_ready low for 3 cycles after the read accept.
//  3. req_valid held high; stream W(8'h01,8'h11), R(8'h01), W(8'h02,8'h22), R(8'h02).
//     -> responses 8'h11, 8'h22.
//     -> bus-contention assertion (drive_en && mem_oe) never fires.
//  4. Boundary addresses: write 8'hFF @8'hFF and 8'h00 @8'h00, then read both.
//     -> 8'hFF, 8'h00; mem_address never shows other values during the accesses.
//  5. Pull rst_n low one cycle into RD.
//     -> cs/oe drop in the same cycle, no rsp_valid.
//     -> a subsequent read @8'h10 returns 8'hA5.
//  6. Sweep READ_WAIT=0 and 3, TURNAROUND=0.
//     -> rsp_valid at accept+1 and accept+4 edges.
//     -> back-to-back read-then-write is accepted at accept+2 for READ_WAIT=0.

Source files
------------

// File: rtl/ram_sp_ctrl_if.sv
// Host request/response and RAM control signals shared by the single-port RAM controller.
// The bidirectional RAM data bus stays a plain inout on the controller.
interface ram_sp_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic                  mem_cs;
    logic                  mem_we;
    logic                  mem_oe;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, mem_address, mem_cs, mem_we, mem_oe
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, mem_address, mem_cs, mem_we, mem_oe
    );
endinterface

// File: rtl/ram_sp_ctrl.sv
// Initiator-side controller for a single-port RAM: synchronous write, asynchronous read,
// shared tri-state data bus with a turnaround gap after reads.
module ram_sp_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int READ_WAIT  = 1,
    parameter int TURNAROUND = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ram_sp_ctrl_if.slave          bus,
    inout  wire  [DATA_WIDTH-1:0] mem_data
);
    typedef enum logic [1:0] {S_IDLE, S_WR, S_RD, S_TA} state_t;

    localparam logic [3:0] LP_RW    = 4'(READ_WAIT);
    localparam logic [3:0] LP_TA_M1 = (TURNAROUND > 0) ? 4'(TURNAROUND - 1) : 4'd0;

    state_t                r_state, w_state;
    logic [3:0]            r_cnt, w_cnt;
    logic                  r_cs, r_we, r_oe, r_drive_en, r_rsp_valid;
    logic                  w_cs, w_we, w_oe, w_drive_en, w_rsp_valid;
    logic [ADDR_WIDTH-1:0] r_addr, w_addr;
    logic [DATA_WIDTH-1:0] r_wdata, w_wdata, r_rdata, w_rdata;

    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_cs        = 1'b0;
        w_we        = 1'b0;
        w_oe        = 1'b0;
        w_drive_en  = 1'b0;
        w_rsp_valid = 1'b0;
        w_addr      = r_addr;
        w_wdata     = r_wdata;
        w_rdata     = r_rdata;
        unique case (r_state)
            S_IDLE: begin
                if (bus.req_valid) begin
                    w_addr  = bus.req_addr;
                    w_wdata = bus.req_wdata;
                    w_cs    = 1'b1;
                    if (bus.req_we) begin
                        w_state    = S_WR;
                        w_we       = 1'b1;
                        w_drive_en = 1'b1;
                    end else begin
                        w_state = S_RD;
                        w_oe    = 1'b1;
                        w_cnt   = LP_RW;
                    end
                end
            end
            S_WR: w_state = S_IDLE;
            S_RD: begin
                // Sample the asynchronous read data on the edge that ends the wait window
                if (r_cnt == 4'd0) begin
                    w_rdata     = mem_data;
                    w_rsp_valid = 1'b1;
                    if (TURNAROUND > 0) begin
                        w_state = S_TA;
                        w_cnt   = LP_TA_M1;
                    end else begin
                        w_state = S_IDLE;
                    end
                end else begin
                    w_cnt = r_cnt - 4'd1;
                    w_cs  = 1'b1;
                    w_oe  = 1'b1;
                end
            end
            S_TA: begin
                if (r_cnt == 4'd0) w_state = S_IDLE;
                else               w_cnt   = r_cnt - 4'd1;
            end
            default: w_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_cs        <= 1'b0;
            r_we        <= 1'b0;
            r_oe        <= 1'b0;
            r_drive_en  <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
        end else begin
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            r_cs        <= w_cs;
            r_we        <= w_we;
            r_oe        <= w_oe;
            r_drive_en  <= w_drive_en;
            r_rsp_valid <= w_rsp_valid;
            r_addr      <= w_addr;
            r_wdata     <= w_wdata;
            r_rdata     <= w_rdata;
        end
    end

    assign bus.req_ready   = (r_state == S_IDLE);
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_rdata   = r_rdata;
    assign bus.mem_address = r_addr;
    assign bus.mem_cs      = r_cs;
    assign bus.mem_we      = r_we;
    assign bus.mem_oe      = r_oe;
    assign mem_data        = r_drive_en ? r_wdata : {DATA_WIDTH{1'bz}};
endmodule

// File: tb/tb_ram_sp_ctrl.sv
// Bench for ram_sp_ctrl: three controller+RAM pairs with different READ_WAIT/TURNAROUND,
// table-driven request stream plus hand-written reset and timing sequences, scoreboarded reads.
module tb_ram_sp_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   viol = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [2:0]       i_valid, i_we;
    logic [2:0][7:0]  i_addr, i_wdata;
    logic [2:0]       o_ready, o_rspv, o_cs, o_we, o_oe, o_drive;
    logic [2:0][7:0]  o_rdata, o_maddr;
    logic [2:0][7:0]  cur_addr = '0;
    logic             prev_oe0 = 1'b0;

    typedef struct { int inst; logic [7:0] data; int due; } exp_t;
    exp_t sbq[$];
    exp_t e;

    function automatic int rw_of(input int g);
        return (g == 0) ? 1 : ((g == 1) ? 0 : 3);
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_inst
        wire [7:0]  mem_data;
        logic [7:0] ram [256];

        ram_sp_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) u_if ();

        ram_sp_ctrl #(
            .DATA_WIDTH(8),
            .ADDR_WIDTH(8),
            .READ_WAIT ((g == 0) ? 1 : ((g == 1) ? 0 : 3)),
            .TURNAROUND((g == 0) ? 1 : 0)
        ) u_dut (
            .clk     (clk),
            .rst_n   (rst_n),
            .bus     (u_if.slave),
            .mem_data(mem_data)
        );

        initial for (int i = 0; i < 256; i++) ram[i] = 8'h00;
        always @(posedge clk) if (u_if.mem_cs && u_if.mem_we) ram[u_if.mem_address] <= mem_data;
        assign mem_data = (u_if.mem_cs && u_if.mem_oe && !u_if.mem_we) ? ram[u_if.mem_address] : 8'bz;

        assign u_if.req_valid = i_valid[g];
        assign u_if.req_we    = i_we[g];
        assign u_if.req_addr  = i_addr[g];
        assign u_if.req_wdata = i_wdata[g];
        assign o_ready[g]     = u_if.req_ready;
        assign o_rspv[g]      = u_if.rsp_valid;
        assign o_rdata[g]     = u_if.rsp_rdata;
        assign o_maddr[g]     = u_if.mem_address;
        assign o_cs[g]        = u_if.mem_cs;
        assign o_we[g]        = u_if.mem_we;
        assign o_oe[g]        = u_if.mem_oe;
        assign o_drive[g]     = u_dut.r_drive_en;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Present a request at a negedge, wait for acceptance, return accept cycle and idle waits
    task automatic issue(input int g, input bit we, input logic [7:0] a, input logic [7:0] d,
                         input bit push, output int acc, output int waits);
        i_valid[g] = 1'b1;
        i_we[g]    = we;
        i_addr[g]  = a;
        i_wdata[g] = d;
        waits = 0;
        acc   = -1;
        while (!o_ready[g] && waits < 40) begin
            @(negedge clk);
            waits++;
        end
        if (!o_ready[g]) begin
            chk("accept_timeout", 32'(o_ready[g]), 32'd1);
        end else begin
            @(posedge clk);
            #1;
            acc         = cyc;
            cur_addr[g] = a;
            if (!we && push) sbq.push_back('{g, d, acc + 1 + rw_of(g)});
            @(negedge clk);
        end
    endtask

    always @(negedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (o_rspv[g]) begin
                if (sbq.size() == 0) begin
                    chk("rsp_unexpected", 32'(o_rspv[g]), 32'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("rsp_inst", g, e.inst);
                    chk("rsp_data", 32'(o_rdata[g]), 32'(e.data));
                    chk("rsp_cycle", cyc, e.due);
                end
            end
            if (o_cs[g]) chk("mem_addr", 32'(o_maddr[g]), 32'(cur_addr[g]));
            if (o_drive[g] && o_oe[g]) viol++;
        end
        // Instance 0 has a turnaround, so the bus may not be driven right after oe falls
        if (o_drive[0] && prev_oe0 && !o_oe[0]) viol++;
        prev_oe0 = o_oe[0];
    end

    typedef struct { bit we; logic [7:0] addr; logic [7:0] data; } vec_t;
    vec_t tbl[10];

    initial begin
        int acc, waits, exp_w, acc_r, acc_w;
        tbl = '{'{1'b1, 8'h10, 8'hA5}, '{1'b0, 8'h10, 8'hA5},
                '{1'b1, 8'h01, 8'h11}, '{1'b0, 8'h01, 8'h11},
                '{1'b1, 8'h02, 8'h22}, '{1'b0, 8'h02, 8'h22},
                '{1'b1, 8'hFF, 8'hFF}, '{1'b1, 8'h00, 8'h00},
                '{1'b0, 8'hFF, 8'hFF}, '{1'b0, 8'h00, 8'h00}};

        rst_n   = 1'b0;
        i_valid = '1;
        i_we    = '1;
        i_addr  = {3{8'h55}};
        i_wdata = {3{8'h77}};
        repeat (3) begin
            @(negedge clk);
            chk("rst_ctrl", 32'({o_cs, o_we, o_oe, o_drive, o_rspv}), 32'd0);
            chk("rst_addr", 32'(o_maddr), 32'd0);
            chk("rst_rdata", 32'(o_rdata), 32'd0);
        end
        i_valid = '0;
        rst_n   = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", 32'(o_ready), 32'b111);
        chk("rst_no_write", 32'(g_inst[0].ram[8'h55]), 32'd0);

        exp_w = 0;
        for (int i = 0; i < 10; i++) begin
            issue(0, tbl[i].we, tbl[i].addr, tbl[i].data, 1'b1, acc, waits);
            chk("ready_gap", waits, exp_w);
            exp_w = tbl[i].we ? 1 : 3;
        end
        i_valid[0] = 1'b0;
        repeat (4) @(negedge clk);

        issue(0, 1'b0, 8'h10, 8'hA5, 1'b0, acc, waits);
        i_valid[0] = 1'b0;
        chk("rd_active", 32'({o_cs[0], o_oe[0]}), 32'b11);
        rst_n = 1'b0;
        #1;
        chk("rst_rd_ctrl", 32'({o_cs[0], o_oe[0], o_rspv[0]}), 32'd0);
        chk("rst_rd_data", 32'(o_rdata[0]), 32'd0);
        @(negedge clk);
        chk("rst_rd_norsp", 32'(o_rspv[0]), 32'd0);
        rst_n = 1'b1;
        issue(0, 1'b0, 8'h10, 8'hA5, 1'b1, acc, waits);
        chk("post_rst_wait", waits, 0);
        i_valid[0] = 1'b0;
        repeat (4) @(negedge clk);

        issue(1, 1'b1, 8'h20, 8'h5A, 1'b0, acc, waits);
        issue(1, 1'b0, 8'h20, 8'h5A, 1'b1, acc_r, waits);
        chk("rw0_wr_gap", waits, 1);
        issue(1, 1'b1, 8'h21, 8'h66, 1'b0, acc_w, waits);
        chk("rw0_rd_gap", waits, 1);
        chk("rw0_b2b_accept", acc_w - acc_r, 2);
        i_valid[1] = 1'b0;
        repeat (3) @(negedge clk);

        issue(2, 1'b1, 8'h30, 8'hC3, 1'b0, acc, waits);
        issue(2, 1'b0, 8'h30, 8'hC3, 1'b1, acc_r, waits);
        issue(2, 1'b1, 8'h31, 8'h00, 1'b0, acc_w, waits);
        chk("rw3_rd_gap", waits, 4);
        chk("rw3_next_accept", acc_w - acc_r, 5);
        i_valid[2] = 1'b0;
        repeat (6) @(negedge clk);

        chk("ram_rw0_wr", 32'(g_inst[1].ram[8'h21]), 32'h66);
        chk("sb_empty", sbq.size(), 0);
        chk("contention", viol, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
